// File: rtl/rsa_pkg.sv
// Shared constants for the RSA datapath: BRAM geometry and write-requester identities.
package rsa_pkg;

  localparam int BRAM_ABITS = 8;
  localparam int BRAM_DBITS = 256;

  typedef enum logic {
    REQ_MONEXP = 1'b0,
    REQ_LOADER = 1'b1
  } req_id_e;

endpackage

// File: rtl/bram_wr_slot.sv
// Single-entry holding slot for one BRAM write requester.
// The slot can be refilled on the same edge that its current contents are granted.
module bram_wr_slot
  import rsa_pkg::*;
#(
  parameter int ABITS = BRAM_ABITS,
  parameter int DBITS = BRAM_DBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [ABITS-1:0] addr,
  input  logic [DBITS-1:0] data,
  input  logic             grant,
  output logic             ready,
  output logic             full,
  output logic [ABITS-1:0] slot_addr,
  output logic [DBITS-1:0] slot_data
);

  assign ready = !full || grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full      <= 1'b0;
      slot_addr <= '0;
      slot_data <= '0;
    end else if (valid && ready) begin
      full      <= 1'b1;
      slot_addr <= addr;
      slot_data <= data;
    end else if (grant) begin
      full      <= 1'b0;
    end
  end

endmodule

// File: rtl/bram_wr_arbiter.sv
// Merges the exponentiator and serial-loader write streams onto the single BRAM write port.
// Each requester owns a one-deep slot; ties between full slots alternate round-robin.
module bram_wr_arbiter
  import rsa_pkg::*;
#(
  parameter int ABITS = BRAM_ABITS,
  parameter int DBITS = BRAM_DBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [ABITS-1:0] req0_addr,
  input  logic [DBITS-1:0] req0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [ABITS-1:0] req1_addr,
  input  logic [DBITS-1:0] req1_data,
  output logic             wr_en,
  output logic [ABITS-1:0] wr_addr,
  output logic [DBITS-1:0] wr_data,
  output logic             busy
);

  logic             full0, full1;
  logic             grant0, grant1;
  logic [ABITS-1:0] slot0_addr, slot1_addr;
  logic [DBITS-1:0] slot0_data, slot1_data;
  req_id_e          rr_last;

  bram_wr_slot #(.ABITS(ABITS), .DBITS(DBITS)) u_slot0 (
    .clk       (clk),
    .rst       (rst),
    .valid     (req0_valid),
    .addr      (req0_addr),
    .data      (req0_data),
    .grant     (grant0),
    .ready     (req0_ready),
    .full      (full0),
    .slot_addr (slot0_addr),
    .slot_data (slot0_data)
  );

  bram_wr_slot #(.ABITS(ABITS), .DBITS(DBITS)) u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .valid     (req1_valid),
    .addr      (req1_addr),
    .data      (req1_data),
    .grant     (grant1),
    .ready     (req1_ready),
    .full      (full1),
    .slot_addr (slot1_addr),
    .slot_data (slot1_data)
  );

  // On a tie the requester that did not win last time takes the port.
  always_comb begin
    grant0 = full0;
    grant1 = full1;
    if (full0 && full1) begin
      grant0 = (rr_last == REQ_LOADER);
      grant1 = (rr_last == REQ_MONEXP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      rr_last <= REQ_LOADER;
    end else begin
      wr_en <= grant0 || grant1;
      if (grant0) begin
        wr_addr <= slot0_addr;
        wr_data <= slot0_data;
        rr_last <= REQ_MONEXP;
      end else if (grant1) begin
        wr_addr <= slot1_addr;
        wr_data <= slot1_data;
        rr_last <= REQ_LOADER;
      end
    end
  end

  assign busy = full0 || full1 || wr_en;

endmodule

// File: tb/tb_bram_wr_arbiter.sv
// Randomized and directed bench for bram_wr_arbiter, checked against a queue-based
// reference model of the two pending-write slots and the round-robin tie rule.
module tb_bram_wr_arbiter;
  import rsa_pkg::*;

  localparam int AW = BRAM_ABITS;
  localparam int DW = BRAM_DBITS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;

  bram_wr_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: one pending-write queue per requester plus the last tie winner.
  logic [AW+DW-1:0] mq0[$];
  logic [AW+DW-1:0] mq1[$];
  int               m_last;
  logic             exp_en;
  logic [AW-1:0]    exp_addr;
  logic [DW-1:0]    exp_data;
  logic             r0_model, r1_model;
  int               cyc;

  logic [AW-1:0]    log_addr[$];
  logic [DW-1:0]    log_data[$];
  int               log_cyc[$];
  logic [DW-1:0]    dut_mem [256];

  task automatic checkOutput(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] randData();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic int pickWinner();
    if (mq0.size() != 0 && mq1.size() != 0) return (m_last == 0) ? 1 : 0;
    if (mq0.size() != 0) return 0;
    if (mq1.size() != 0) return 1;
    return -1;
  endfunction

  function automatic void clearLog();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
  endfunction

  // One clock of stimulus; ready is checked before the edge, the write port after it.
  task automatic applyStimulus(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    int               win;
    logic [AW+DW-1:0] e;
    e = '0;
    @(negedge clk);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    win = pickWinner();
    r0_model = (mq0.size() == 0) || (win == 0);
    r1_model = (mq1.size() == 0) || (win == 1);
    #1;
    checkOutput("req0_ready", DW'(req0_ready), DW'(r0_model));
    checkOutput("req1_ready", DW'(req1_ready), DW'(r1_model));
    @(posedge clk);
    if (win == 0) e = mq0.pop_front();
    else if (win == 1) e = mq1.pop_front();
    if (win >= 0) begin
      exp_en   = 1'b1;
      exp_addr = e[AW+DW-1:DW];
      exp_data = e[DW-1:0];
      m_last   = win;
    end else begin
      exp_en = 1'b0;
    end
    if (v0 && r0_model) mq0.push_back({a0, d0});
    if (v1 && r1_model) mq1.push_back({a1, d1});
    #1;
    checkOutput("wr_en", DW'(wr_en), DW'(exp_en));
    checkOutput("wr_addr", DW'(wr_addr), DW'(exp_addr));
    checkOutput("wr_data", wr_data, exp_data);
    checkOutput("busy", DW'(busy), DW'(mq0.size() != 0 || mq1.size() != 0 || exp_en));
    if (wr_en === 1'b1) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
      log_cyc.push_back(cyc + 1);
      dut_mem[wr_addr] = wr_data;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic applyReset();
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b1;
    mq0.delete();
    mq1.delete();
    m_last   = 1;
    exp_en   = 1'b0;
    exp_addr = '0;
    exp_data = '0;
    #1;
    checkOutput("rst_wr_en", DW'(wr_en), '0);
    checkOutput("rst_busy", DW'(busy), '0);
    checkOutput("rst_wr_addr", DW'(wr_addr), '0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ready0", DW'(req0_ready), DW'(1));
    checkOutput("post_rst_ready1", DW'(req1_ready), DW'(1));
    checkOutput("post_rst_busy", DW'(busy), '0);
    checkOutput("post_rst_wr_en", DW'(wr_en), '0);
  endtask

  initial begin
    int            k0, k1, j0, j1;
    logic [DW-1:0] data_a, data_b;

    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    cyc = 0;
    for (int i = 0; i < 256; i++) dut_mem[i] = '0;
    applyReset();

    // First tie after reset goes to requester 0.
    clearLog();
    applyStimulus(1'b1, AW'(8'h10), randData(), 1'b1, AW'(8'h20), randData());
    idle(4);
    checkOutput("tie_count", DW'(log_addr.size()), DW'(2));
    checkOutput("tie_first", DW'(log_addr[0]), DW'(8'h10));
    checkOutput("tie_second", DW'(log_addr[1]), DW'(8'h20));
    checkOutput("tie_gap", DW'(log_cyc[1] - log_cyc[0]), DW'(1));

    $display("[TB] latency");
    clearLog();
    k0 = cyc;
    applyStimulus(1'b1, AW'(8'h05), {32{8'hAB}}, 1'b0, '0, '0);
    idle(3);
    checkOutput("lat_count", DW'(log_addr.size()), DW'(1));
    checkOutput("lat_addr", DW'(log_addr[0]), DW'(8'h05));
    checkOutput("lat_data", log_data[0], {32{8'hAB}});
    checkOutput("lat_cycles", DW'(log_cyc[0] - k0), DW'(2));

    // Requester 0 won last, so an overlapping tie grants 1,0,1.
    clearLog();
    k0 = 0; k1 = 0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, AW'(8'h10 + k0), randData(), 1'b1, AW'(8'hA0 + k1), randData());
      if (r0_model) k0++;
      if (r1_model) k1++;
    end
    idle(4);
    checkOutput("rtie_count", DW'(log_addr.size()), DW'(3));
    checkOutput("rtie_src0", DW'(log_addr[0][7]), DW'(1));
    checkOutput("rtie_src1", DW'(log_addr[1][7]), DW'(0));
    checkOutput("rtie_src2", DW'(log_addr[2][7]), DW'(1));

    $display("[TB] streaming");
    clearLog();
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, '0, 1'b1, AW'(i), randData());
    idle(3);
    checkOutput("stream_count", DW'(log_addr.size()), DW'(8));
    for (int i = 0; i < 8; i++) begin
      checkOutput("stream_addr", DW'(log_addr[i]), DW'(i));
      checkOutput("stream_gap", DW'(log_cyc[i] - log_cyc[0]), DW'(i));
    end

    $display("[TB] contention");
    clearLog();
    k0 = 0; k1 = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, AW'(k0), randData(), 1'b1, AW'(8'h80 + k1), randData());
      if (r0_model) k0++;
      if (r1_model) k1++;
    end
    idle(4);
    checkOutput("cont_count", DW'(log_addr.size()), DW'(k0 + k1));
    for (int i = 1; i < 10; i++)
      checkOutput("cont_alt", DW'(log_addr[i][7] ^ log_addr[i-1][7]), DW'(1));
    j0 = 0; j1 = 0;
    for (int i = 0; i < log_addr.size(); i++) begin
      if (log_addr[i][7]) begin
        checkOutput("cont_order1", DW'(log_addr[i]), DW'(8'h80 + j1));
        j1++;
      end else begin
        checkOutput("cont_order0", DW'(log_addr[i]), DW'(j0));
        j0++;
      end
    end

    $display("[TB] same address");
    applyStimulus(1'b1, AW'(8'h33), randData(), 1'b0, '0, '0);
    idle(3);
    clearLog();
    data_a = randData();
    data_b = ~data_a;
    applyStimulus(1'b1, AW'(3), data_a, 1'b1, AW'(3), data_b);
    idle(4);
    checkOutput("same_first", log_data[0], data_b);
    checkOutput("same_second", log_data[1], data_a);
    checkOutput("same_mem", dut_mem[3], data_a);

    $display("[TB] random");
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(0, 1)), AW'($urandom()), randData(),
                    1'($urandom_range(0, 1)), AW'($urandom()), randData());

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, AW'(8'h44), randData(), 1'b1, AW'(8'h55), randData());
    applyStimulus(1'b1, AW'(8'h46), randData(), 1'b1, AW'(8'h57), randData());
    applyReset();
    clearLog();
    idle(5);
    checkOutput("rst_no_write", DW'(log_addr.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
